// File: rtl/gray_ptr_receiver_if.sv
// Port bundle for the Gray write-pointer receiver.
// The master side drives the remote write pointer, the local next read pointer
// and the error clear. The slave side returns the read-domain status flags.
interface gray_ptr_receiver_if #(
  parameter int N = 4
);

  // Remote Gray write pointer, asynchronous to the receiving clock.
  logic [N:0] wgptr_async;
  // Local next Gray read pointer, synchronous to the receiving clock.
  logic [N:0] rgptr_next;
  // Synchronous clear of the sticky pointer error.
  logic       err_clr;

  // Registered status returned by the receiver.
  logic       empty;
  logic       almost_empty;
  logic [N:0] level;
  logic       ptr_err;
  logic [N:0] wgptr_sync;

  modport master (
    output wgptr_async,
    output rgptr_next,
    output err_clr,
    input  empty,
    input  almost_empty,
    input  level,
    input  ptr_err,
    input  wgptr_sync
  );

  modport slave (
    input  wgptr_async,
    input  rgptr_next,
    input  err_clr,
    output empty,
    output almost_empty,
    output level,
    output ptr_err,
    output wgptr_sync
  );

endinterface

// File: rtl/gray_ptr_receiver.sv
// Read-domain receiver for an asynchronous FIFO write pointer.
// A Gray write pointer is brought through a flop chain. It is decoded against
// the local next read pointer to give registered empty, almost-empty and
// occupancy. A sticky error flags pointer steps that are not legal Gray code
// and occupancies that cannot exist.
module gray_ptr_receiver #(
  parameter int N           = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AE_THRESH   = 1
) (
  input logic                clk,
  input logic                rst_n,
  gray_ptr_receiver_if.slave bus
);

  localparam int            PW       = N + 1;
  localparam logic [PW-1:0] AE_LVL   = PW'(AE_THRESH);
  localparam logic [PW-1:0] FULL_LVL = PW'(2 ** N);

  // Gray to binary: the MSB passes through, and each lower bit folds in every bit above it.
  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // True when more than one bit is set. Clearing the lowest set bit leaves a
  // nonzero value only if another bit was also set.
  function automatic logic multi_bit(input logic [PW-1:0] x);
    return (x & (x - PW'(1))) != '0;
  endfunction

  // Synchronizer chain: stage 0 samples the asynchronous pointer. wq_s is the last stage.
  logic [PW-1:0] wq_p [SYNC_STAGES];
  logic [PW-1:0] wq_s;

  // Previous value of wq_s, used to catch illegal multi-bit Gray steps.
  logic [PW-1:0] wq_prev;

  // Combinational decode of both pointers.
  logic [PW-1:0] wbin_s;
  logic [PW-1:0] rbin_next;
  logic [PW-1:0] level_next;
  logic          empty_next;
  logic          ae_next;
  logic          step_err;
  logic          ovf_err;
  logic          err_set;

  // Registered status.
  logic [PW-1:0] level_q;
  logic          empty_q;
  logic          ae_q;
  logic          ptr_err_q;

  // Shift the remote pointer through the synchronizer with no logic between stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        wq_p[i] <= '0;
      end
    end else begin
      wq_p[0] <= bus.wgptr_async;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        wq_p[i] <= wq_p[i-1];
      end
    end
  end

  assign wq_s = wq_p[SYNC_STAGES-1];

  // ---- stage boundary: synchronized pointer -> decoded occupancy ----

  // Decode both pointers and form the next-state flags. The subtraction wraps
  // modulo 2^(N+1), so pointer wrap-around needs no special handling.
  always_comb begin
    wbin_s     = gray2bin(wq_s);
    rbin_next  = gray2bin(bus.rgptr_next);
    level_next = wbin_s - rbin_next;
    empty_next = (wq_s == bus.rgptr_next);
    ae_next    = (level_next <= AE_LVL);
    step_err   = multi_bit(wq_s ^ wq_prev);
    ovf_err    = (level_next > FULL_LVL);
    err_set    = step_err || ovf_err;
  end

  // Remember the last synchronized pointer for the Gray-step check.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wq_prev <= '0;
    end else begin
      wq_prev <= wq_s;
    end
  end

  // Register occupancy and the empty/almost-empty flags on every edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
      empty_q <= 1'b1;
      ae_q    <= 1'b1;
    end else begin
      level_q <= level_next;
      empty_q <= empty_next;
      ae_q    <= ae_next;
    end
  end

  // Sticky integrity error: a new error takes priority over a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_err_q <= 1'b0;
    end else if (err_set) begin
      ptr_err_q <= 1'b1;
    end else if (bus.err_clr) begin
      ptr_err_q <= 1'b0;
    end
  end

  // ---- stage boundary: registered status -> outputs ----

  assign bus.empty        = empty_q;
  assign bus.almost_empty = ae_q;
  assign bus.level        = level_q;
  assign bus.ptr_err      = ptr_err_q;
  assign bus.wgptr_sync   = wq_s;

endmodule
